// File: rtl/regfile_dump_reader.sv
// Walks a register-file read port from 0 to NUM_REGS-1 and streams each word out over valid/ready.
// Optional DUMP_CHECKSUM_EN appends one XOR-checksum word after the last register.
module regfile_dump_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic              accept;
    logic              hshake;
    logic              at_last;

    assign accept   = (state == S_IDLE) && start;
    assign hshake   = (state == S_SEND) && out_ready;
    assign at_last  = (idx == LAST_IDX);
    assign idx_next = idx + ADDR_W'(1);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign out_valid = (state == S_SEND);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              csum_turn;

    // The checksum word follows the last register straight out of SEND, no LOAD needed.
    assign csum_turn = hshake && at_last && !out_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum <= '0;
        else if (accept)
            csum <= '0;
        else if (state == S_LOAD)
            csum <= csum ^ rf_data;
    end
`endif

    // rf_addr is loaded one cycle early so it already equals idx during LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            rf_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        state   <= S_LOAD;
                        rf_addr <= '0;
                    end
                end
                S_LOAD: state <= S_SEND;
                S_SEND: begin
                    if (hshake) begin
                        if (out_last) begin
                            state <= S_FIN;
`ifdef DUMP_CHECKSUM_EN
                        end else if (at_last) begin
                            state <= S_SEND;
`endif
                        end else begin
                            idx     <= idx_next;
                            rf_addr <= idx_next;
                            state   <= S_LOAD;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else if (state == S_LOAD) begin
            out_data <= rf_data;
            out_addr <= idx;
`ifdef DUMP_CHECKSUM_EN
            out_last <= 1'b0;
`else
            out_last <= at_last;
`endif
`ifdef DUMP_CHECKSUM_EN
        end else if (csum_turn) begin
            out_data <= csum;
            out_addr <= '0;
            out_last <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a word-list model of the dump.
module tb_regfile_dump_reader;

    localparam int NUM = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int TOTAL = NUM + CS;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rf_addr, out_addr;
    logic [31:0] rf_data, out_data;

    logic [31:0] regs [NUM];
    logic [31:0] exp_data [NUM];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    assign rf_data = regs[rf_addr];

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NUM)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last)
    );

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Word p of a dump: registers in order, then optionally the XOR of them all.
    function automatic void exp_word(input int p, output logic [31:0] d, output logic [4:0] a, output logic l);
        if (p < NUM) begin
            d = exp_data[p];
            a = 5'(p);
            l = (p == NUM - 1) && (CS == 0);
        end else begin
            d = '0;
            for (int i = 0; i < NUM; i++) d = d ^ exp_data[i];
            a = '0;
            l = 1'b1;
        end
    endfunction

    // Model: busy from accepted start until the cycle after the final handshake.
    int          w_cnt = 0;
    bit          m_busy = 0, m_fin = 0, held = 0;
    logic [31:0] p_data;
    logic [4:0]  p_addr;
    logic        p_last;

    always @(negedge clk) begin
        logic [31:0] ed;
        logic [4:0]  ea;
        logic        el;
        bit          nf;
        if (reset) begin
            chk(!busy && !done && !out_valid && !out_last && out_data == 0 && out_addr == 0 && rf_addr == 0,
                "reset_zero", {busy, done, out_valid, out_last, out_data}, 0);
            m_busy = 0; m_fin = 0; held = 0; w_cnt = 0;
        end else begin
            chk(busy == m_busy, "busy", busy, m_busy);
            chk(done == m_fin, "done", done, m_fin);
            if (!m_busy || m_fin) chk(!out_valid, "valid_idle", out_valid, 0);
            if (held)
                chk(out_valid && out_data == p_data && out_addr == p_addr && out_last == p_last,
                    "hold_stable", {out_valid, out_addr, out_data}, {1'b1, p_addr, p_data});
            if (out_valid) begin
                if (w_cnt >= TOTAL) begin
                    chk(0, "extra_word", w_cnt, TOTAL);
                end else begin
                    exp_word(w_cnt, ed, ea, el);
                    chk(out_data == ed, "data", out_data, ed);
                    chk(out_addr == ea, "addr", out_addr, ea);
                    chk(out_last == el, "last", out_last, el);
                end
            end
            held = out_valid && !out_ready;
            p_data = out_data; p_addr = out_addr; p_last = out_last;
            nf = 0;
            if (m_fin) m_busy = 0;
            else if (!m_busy && start) begin
                m_busy = 1;
                w_cnt = 0;
                for (int i = 0; i < NUM; i++) exp_data[i] = regs[i];
            end
            if (out_valid && out_ready) begin
                if (w_cnt == TOTAL - 1) nf = 1;
                w_cnt++;
            end
            m_fin = nf;
        end
    end

    task automatic preload;
        for (int i = 0; i < NUM; i++) regs[i] = 32'hA5A50000 + 32'(i);
    endtask

    // Runs one dump from IDLE; cyc counts cycles from start assertion to visible done.
    task automatic dump(input bit rnd, input bit wr, input int stall_at, input int bump_at, output int cyc);
        bit          ok = 0, stalled = 0, bumped = 0;
        int          stall_n = 0;
        int          j;
        logic [31:0] v;
        start = 1; out_ready = 1; cyc = 0;
        while (cyc < 4000 && !ok) begin
            tick;
            cyc++;
            start = 0;
            if (cyc == 1) chk(busy && !out_valid, "start_to_load", {busy, out_valid}, 2'b10);
            if (cyc == 2) chk(out_valid && out_addr == 0, "first_valid", {out_valid, out_addr}, 6'h20);
            if (done) begin
                ok = 1;
            end else begin
                if (bump_at >= 0 && out_valid && out_addr == 5'(bump_at) && !bumped) begin
                    start = 1; bumped = 1;
                end
                if (stall_n > 0) begin
                    chk(out_valid && out_addr == 5'(stall_at) && out_data == 32'hA5A50000 + 32'(stall_at),
                        "bp_hold", {out_valid, out_addr, out_data}, {1'b1, 5'(stall_at), 32'hA5A50000 + 32'(stall_at)});
                    stall_n--;
                    out_ready = (stall_n == 0);
                end else if (stall_at >= 0 && out_valid && out_addr == 5'(stall_at) && !stalled) begin
                    stalled = 1; stall_n = 5; out_ready = 0;
                end else begin
                    out_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
                end
                if (wr && out_valid && !out_last && ($urandom % 3 == 0)) begin
                    j = int'($urandom % NUM);
                    v = $urandom;
                    regs[j] = v;
                    if (j > int'(out_addr)) exp_data[j] = v;
                end
            end
        end
        if (!ok) chk(0, "dump_timeout", cyc, 0);
        if (stall_at >= 0) chk(stalled, "bp_reached", stalled, 1);
    endtask

    initial begin
        int cyc, n;
        reset = 1; start = 1; out_ready = 0;
        preload;
        repeat (3) tick;
        reset = 0; start = 0;
        tick;

        // Full dump with ready high, a start at index 10 and another in FIN.
        dump(0, 0, -1, 10, cyc);
        chk(cyc == 2 * NUM + 1 + CS, "dump_len", cyc, 2 * NUM + 1 + CS);
        start = 1;
        tick;
        start = 0;
        chk(!busy && !done, "fin_start_ignored", {busy, done}, 0);
        tick;

        // Backpressure on index 3.
        dump(0, 0, 3, -1, cyc);
        tick;

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NUM; i++) regs[i] = $urandom;
            dump(1, 1, -1, -1, cyc);
            repeat (1 + $urandom % 3) tick;
        end

        // Reset while SEND is holding index 17.
        preload;
        start = 1; out_ready = 1; n = 0;
        do begin
            tick;
            start = 0;
            n++;
        end while (!(out_valid && out_addr == 5'd17) && n < 200);
        chk(n < 200, "reach_idx17", n, 200);
        out_ready = 0;
        tick;
        #2 reset = 1;
        #1 chk(!out_valid && !busy && !done && out_data == 0, "async_abort",
               {out_valid, busy, done, out_data}, 0);
        tick;
        reset = 0;
        tick;
        dump(1, 0, -1, -1, cyc);
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
